// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/and/or/sll/sra, iterative signed mul/div
// (one bit per cycle), valid/ready handshake on both sides, registered flags.
module alu_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               exception
);

  localparam int unsigned    CNT_W   = $clog2(WIDTH);
  localparam logic [4:0]     OP_ADD  = 5'b00000;
  localparam logic [4:0]     OP_SUB  = 5'b00001;
  localparam logic [4:0]     OP_AND  = 5'b00010;
  localparam logic [4:0]     OP_OR   = 5'b00011;
  localparam logic [4:0]     OP_SLL  = 5'b00100;
  localparam logic [4:0]     OP_SRA  = 5'b00101;
  localparam logic [4:0]     OP_MUL  = 5'b00110;
  localparam logic [4:0]     OP_DIV  = 5'b00111;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mag_q, mag_d;
  logic               is_div_q, is_div_d, neg_q, neg_d;
  logic               ne_p_q, ne_p_d, lt_p_q, lt_p_d, dovf_q, dovf_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d;

  logic [WIDTH-1:0]   a_abs, b_abs, sum, diff;
  logic               add_ovf, sub_ovf, cmp_ne, cmp_lt, accept, long_op;
  logic [WIDTH:0]     mul_sum, div_sh, div_tr;
  logic [WIDTH-1:0]   step_hi, step_lo, quot;
  logic [2*WIDTH-1:0] prod_s;
  logic               mul_ovf;

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == DONE);
  assign data_result = res_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ovf_q;
  assign exception   = exc_q;

  // Operand-side arithmetic and comparison flags for the request at the inputs.
  always_comb begin
    a_abs   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_abs   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    sum     = data_operandA + data_operandB;
    diff    = data_operandA - data_operandB;
    add_ovf = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
              (sum[WIDTH-1] != data_operandA[WIDTH-1]);
    sub_ovf = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
              (diff[WIDTH-1] != data_operandA[WIDTH-1]);
    cmp_ne  = (diff != '0);
    cmp_lt  = diff[WIDTH-1] ^ sub_ovf;
    accept  = in_valid && in_ready_q;
    long_op = (ctrl_ALUopcode == OP_MUL) ||
              ((ctrl_ALUopcode == OP_DIV) && (data_operandB != '0));
  end

  // One iteration of the magnitude datapath; hi/lo are shared by mul (accumulator /
  // multiplier) and div (remainder / dividend-then-quotient). Sign is reapplied last.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_tr  = div_sh - {1'b0, mag_q};
    if (is_div_q) begin
      if (!div_tr[WIDTH]) begin
        step_hi = div_tr[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod_s  = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || ~(|prod_s[2*WIDTH-1:WIDTH-1]));
    quot    = neg_q ? -step_lo : step_lo;
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mag_d    = mag_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    ne_p_d   = ne_p_q;
    lt_p_d   = lt_p_q;
    dovf_d   = dovf_q;
    res_d    = res_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    ovf_d    = ovf_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (long_op) begin
            state_d  = CALC;
            cnt_d    = '0;
            hi_d     = '0;
            is_div_d = (ctrl_ALUopcode == OP_DIV);
            lo_d     = (ctrl_ALUopcode == OP_DIV) ? a_abs : b_abs;
            mag_d    = (ctrl_ALUopcode == OP_DIV) ? b_abs : a_abs;
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ne_p_d   = cmp_ne;
            lt_p_d   = cmp_lt;
            dovf_d   = (ctrl_ALUopcode == OP_DIV) && (data_operandA == MIN_NEG) &&
                       (data_operandB == '1);
          end else begin
            state_d = DONE;
            ne_d    = cmp_ne;
            lt_d    = cmp_lt;
            res_d   = '0;
            ovf_d   = 1'b0;
            exc_d   = 1'b0;
            case (ctrl_ALUopcode)
              OP_ADD: begin res_d = sum;  ovf_d = add_ovf; end
              OP_SUB: begin res_d = diff; ovf_d = sub_ovf; end
              OP_AND: res_d = data_operandA & data_operandB;
              OP_OR:  res_d = data_operandA | data_operandB;
              OP_SLL: res_d = data_operandA << ctrl_shiftamt;
              OP_SRA: res_d = $signed(data_operandA) >>> ctrl_shiftamt;
              default: exc_d = 1'b1;
            endcase
          end
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          ne_d    = ne_p_q;
          lt_d    = lt_p_q;
          exc_d   = 1'b0;
          res_d   = is_div_q ? quot : prod_s[WIDTH-1:0];
          ovf_d   = is_div_q ? dovf_q : mul_ovf;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset drops any in-flight operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mag_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      ne_p_q     <= 1'b0;
      lt_p_q     <= 1'b0;
      dovf_q     <= 1'b0;
      res_q      <= '0;
      ne_q       <= 1'b0;
      lt_q       <= 1'b0;
      ovf_q      <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mag_q      <= mag_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      ne_p_q     <= ne_p_d;
      lt_p_q     <= lt_p_d;
      dovf_q     <= dovf_d;
      res_q      <= res_d;
      ne_q       <= ne_d;
      lt_q       <= lt_d;
      ovf_q      <= ovf_d;
      exc_q      <= exc_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): directed corner cases plus random operations,
// checked against a plain-arithmetic reference model.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_result;
  logic        isNotEqual, isLessThan, overflow, exception;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        ne, lt, ovf, exc;
    int          lat;
  } exp_t;

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow),
    .exception      (exception)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic fits32(input longint v);
    logic [31:0] lo;
    lo = v[31:0];
    return v == longint'($signed(lo));
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t   e;
    longint sa, sb, r;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.ne  = (sa != sb);
    e.lt  = (sa < sb);
    e.ovf = 1'b0;
    e.exc = 1'b0;
    e.res = '0;
    e.lat = 1;
    case (op)
      5'd0: begin r = sa + sb; e.res = r[31:0]; e.ovf = !fits32(r); end
      5'd1: begin r = sa - sb; e.res = r[31:0]; e.ovf = !fits32(r); end
      5'd2: e.res = a & b;
      5'd3: e.res = a | b;
      5'd4: e.res = a << sh;
      5'd5: e.res = $signed(a) >>> sh;
      5'd6: begin r = sa * sb; e.res = r[31:0]; e.ovf = !fits32(r); e.lat = 33; end
      5'd7: begin
        if (b == 0) e.exc = 1'b1;
        else begin r = sa / sb; e.res = r[31:0]; e.ovf = !fits32(r); e.lat = 33; end
      end
      default: e.exc = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".res"}, 64'(data_result), 64'(e.res));
    chk({tag, ".ne"},  64'(isNotEqual),  64'(e.ne));
    chk({tag, ".lt"},  64'(isLessThan),  64'(e.lt));
    chk({tag, ".ovf"}, 64'(overflow),    64'(e.ovf));
    chk({tag, ".exc"}, 64'(exception),   64'(e.exc));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(0));
    chk({tag, ".res"},       64'(data_result), 64'(0));
    chk({tag, ".flags"},     64'({isNotEqual, isLessThan, overflow, exception}), 64'(0));
  endtask

  // Issue one operation, scramble inputs right after acceptance, measure latency,
  // hold DONE for 'hold' cycles, then release with in_valid still high.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int hold);
    exp_t e;
    int   lat;
    e = model(op, a, b, sh);
    @(negedge clock);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
    in_valid       = 1'b1;
    @(posedge clock); #1;
    in_valid       = 1'b0;
    data_operandA  = $urandom;
    data_operandB  = $urandom;
    ctrl_ALUopcode = 5'($urandom);
    ctrl_shiftamt  = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
    check_outputs(tag, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
      chk({tag, ".hold_ready"}, 64'(in_ready), 64'(0));
      chk({tag, ".hold_res"},   64'(data_result), 64'(e.res));
    end
    @(negedge clock);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".release_valid"}, 64'(out_valid), 64'(0));
    chk({tag, ".release_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    reset          = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    data_operandA  = '0;
    data_operandB  = '0;
    ctrl_ALUopcode = '0;
    ctrl_shiftamt  = '0;
    repeat (2) @(posedge clock);
    #1 check_cleared("reset");
    @(negedge clock);
    reset = 1'b1;
    #1 chk("post_reset.in_ready_before_edge", 64'(in_ready), 64'(0));
    @(posedge clock); #1;
    chk("post_reset.in_ready_after_edge", 64'(in_ready), 64'(1));

    run_op("add_ovf",    5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    run_op("mul_neg",    5'd6, 32'hFFFF_FFFD, 32'h0000_0007, 5'd0, 0);
    run_op("mul_ovf",    5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, 0);
    run_op("div_trunc",  5'd7, 32'hFFFF_FFF9, 32'h0000_0002, 5'd0, 0);
    run_op("div_zero",   5'd7, 32'h0000_0005, 32'h0000_0000, 5'd0, 0);
    run_op("div_ovf",    5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    run_op("illegal",    5'd10, 32'h0000_0003, 32'h0000_0009, 5'd0, 0);
    run_op("sub_hold",   5'd1, 32'h8000_0000, 32'h0000_0001, 5'd0, 10);
    run_op("mul_minneg", 5'd6, 32'h8000_0000, 32'h8000_0000, 5'd0, 1);
    run_op("sll_31",     5'd4, 32'h0000_0003, 32'h0000_0000, 5'd31, 0);

    // Reset during CALC of a multiply
    @(negedge clock);
    data_operandA  = 32'h1234_5678;
    data_operandB  = 32'h0000_0777;
    ctrl_ALUopcode = 5'd6;
    in_valid       = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clock);
    #3 reset = 1'b0;
    #1 check_cleared("mid_calc_reset");
    repeat (2) @(posedge clock);
    #1 check_cleared("mid_calc_reset_held");
    @(negedge clock);
    reset = 1'b1;
    #1 chk("mid_calc_release.in_ready_before_edge", 64'(in_ready), 64'(0));
    @(posedge clock); #1;
    chk("mid_calc_release.in_ready", 64'(in_ready), 64'(1));
    repeat (40) @(posedge clock);
    #1 chk("mid_calc_release.dropped", 64'(out_valid), 64'(0));
    run_op("sra_after_reset", 5'd5, 32'h8000_0000, 32'h0000_0000, 5'd4, 0);

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 10));
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 20)) - 32'd10;
        1:       a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = 32'($urandom_range(0, 20)) - 32'd10;
        2:       b = a;
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d_op%0d", n, op), op, a, b, 5'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
